// File: rtl/day_cycle_sequencer.sv
// Day/night fade sequencer.
// Counts frames on vsync rising edges and walks a repeating NIGHT -> RISE -> DAY -> SET cycle.
// fade_level ramps 0 -> 255 during RISE and 255 -> 0 during SET, one step every STEP_FRAMES
// frames. A pause level freezes everything, and a restart pulse jumps to the start of RISE.
module day_cycle_sequencer #(
  parameter int unsigned STEP_FRAMES  = 2,
  parameter int unsigned HOLD_FRAMES  = 60,
  parameter int unsigned NIGHT_FRAMES = 60
) (
  input  logic       clk_pix,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       pause,
  input  logic       restart,
  output logic [7:0] fade_level,
  output logic       direction,
  output logic [1:0] phase,
  output logic       cycle_done
);

  // Phase encoding is visible on the phase port, so these values are fixed.
  localparam logic [1:0] StNight = 2'd0;
  localparam logic [1:0] StRise  = 2'd1;
  localparam logic [1:0] StDay   = 2'd2;
  localparam logic [1:0] StSet   = 2'd3;

  // Terminal counts, truncated to the 8-bit counter width.
  localparam logic [7:0] StepLast  = 8'(STEP_FRAMES - 1);
  localparam logic [7:0] HoldLast  = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0] NightLast = 8'(NIGHT_FRAMES - 1);

  logic       vsync_q;
  logic [1:0] phase_q, phase_d;
  logic [7:0] fade_q, fade_d;
  logic       dir_q, dir_d;
  logic       done_q, done_d;
  logic [7:0] pre_cnt_q, pre_cnt_d;
  logic [7:0] dwell_q, dwell_d;

  logic tick;
  logic step;

  // A frame tick is a vsync rising edge seen while not paused. An edge seen during pause is lost.
  assign tick = vsync & ~vsync_q & ~pause;
  assign step = tick & (pre_cnt_q == StepLast);

  // Next-state logic. restart overrides pause and any tick in the same cycle.
  always_comb begin
    phase_d   = phase_q;
    fade_d    = fade_q;
    dir_d     = dir_q;
    pre_cnt_d = pre_cnt_q;
    dwell_d   = dwell_q;
    done_d    = 1'b0;

    if (restart) begin
      phase_d   = StRise;
      fade_d    = 8'd0;
      dir_d     = 1'b0;
      pre_cnt_d = 8'd0;
      dwell_d   = 8'd0;
    end else if (tick) begin
      case (phase_q)
        StNight: begin
          if (dwell_q == NightLast) begin
            phase_d   = StRise;
            dir_d     = 1'b0;
            dwell_d   = 8'd0;
            pre_cnt_d = 8'd0;
            done_d    = 1'b1;
          end else begin
            dwell_d = dwell_q + 8'd1;
          end
        end

        StRise: begin
          if (step) begin
            pre_cnt_d = 8'd0;
            // Saturate at 255 and hand over to DAY on the final step.
            if (fade_q >= 8'd254) begin
              fade_d  = 8'd255;
              phase_d = StDay;
              dwell_d = 8'd0;
            end else begin
              fade_d = fade_q + 8'd1;
            end
          end else begin
            pre_cnt_d = pre_cnt_q + 8'd1;
          end
        end

        StDay: begin
          if (dwell_q == HoldLast) begin
            phase_d   = StSet;
            dir_d     = 1'b1;
            dwell_d   = 8'd0;
            pre_cnt_d = 8'd0;
          end else begin
            dwell_d = dwell_q + 8'd1;
          end
        end

        default: begin // StSet
          if (step) begin
            pre_cnt_d = 8'd0;
            // Saturate at 0 and hand over to NIGHT on the final step.
            if (fade_q <= 8'd1) begin
              fade_d  = 8'd0;
              phase_d = StNight;
              dwell_d = 8'd0;
            end else begin
              fade_d = fade_q - 8'd1;
            end
          end else begin
            pre_cnt_d = pre_cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  // vsync history register; samples every cycle, even while paused or restarting.
  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= vsync;
    end
  end

  // Sequencer state and counters, synchronous active-low reset.
  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      phase_q   <= StNight;
      fade_q    <= 8'd0;
      dir_q     <= 1'b1;
      done_q    <= 1'b0;
      pre_cnt_q <= 8'd0;
      dwell_q   <= 8'd0;
    end else begin
      phase_q   <= phase_d;
      fade_q    <= fade_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      pre_cnt_q <= pre_cnt_d;
      dwell_q   <= dwell_d;
    end
  end

  assign fade_level = fade_q;
  assign direction  = dir_q;
  assign phase      = phase_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_day_cycle_sequencer.sv
// Self-checking bench for day_cycle_sequencer.
// Two instances share all inputs: dut (STEP_FRAMES=1) for the main sequence and dut3
// (STEP_FRAMES=3) for the prescaler scenario.
module tb_day_cycle_sequencer;

  logic       clk_pix = 1'b0;
  logic       rst_n;
  logic       vsync;
  logic       pause;
  logic       restart;
  logic [7:0] fade_level;
  logic       direction;
  logic [1:0] phase;
  logic       cycle_done;
  logic [7:0] fade3;
  logic       dir3;
  logic [1:0] phase3;
  logic       done3;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  typedef struct {
    string name;
    int    n_pulses;
    bit    pz;
    int    ph;
    int    fade;
    int    dir;
    int    done;
  } vec_t;

  vec_t vecs[11];
  vec_t sb[$];
  int   q3[$];

  always #5 clk_pix = ~clk_pix;

  day_cycle_sequencer #(
    .STEP_FRAMES (1),
    .HOLD_FRAMES (3),
    .NIGHT_FRAMES(2)
  ) dut (
    .clk_pix   (clk_pix),
    .rst_n     (rst_n),
    .vsync     (vsync),
    .pause     (pause),
    .restart   (restart),
    .fade_level(fade_level),
    .direction (direction),
    .phase     (phase),
    .cycle_done(cycle_done)
  );

  day_cycle_sequencer #(
    .STEP_FRAMES (3),
    .HOLD_FRAMES (3),
    .NIGHT_FRAMES(2)
  ) dut3 (
    .clk_pix   (clk_pix),
    .rst_n     (rst_n),
    .vsync     (vsync),
    .pause     (pause),
    .restart   (restart),
    .fade_level(fade3),
    .direction (dir3),
    .phase     (phase3),
    .cycle_done(done3)
  );

  function automatic vec_t mk(string name, int n, bit pz, int ph, int fade, int dir, int done);
    vec_t v;
    v.name     = name;
    v.n_pulses = n;
    v.pz       = pz;
    v.ph       = ph;
    v.fade     = fade;
    v.dir      = dir;
    v.done     = done;
    return v;
  endfunction

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk_pix);
    #1;
    if (cycle_done) done_seen++;
  endtask

  task automatic pulse();
    vsync = 1'b1;
    repeat (4) cyc();
    vsync = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse();
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    vec_t exp_v;

    vecs[0]  = mk("first_wrap", 2,   1'b0, 1, 0,   0, 1);
    vecs[1]  = mk("full_rise",  255, 1'b0, 2, 255, 0, 0);
    vecs[2]  = mk("day_hold",   3,   1'b0, 3, 255, 1, 0);
    vecs[3]  = mk("full_set",   255, 1'b0, 0, 0,   1, 0);
    vecs[4]  = mk("second_wrap",2,   1'b0, 1, 0,   0, 1);
    vecs[5]  = mk("rise_to_10", 10,  1'b0, 1, 10,  0, 0);
    vecs[6]  = mk("paused",     5,   1'b1, 1, 10,  0, 0);
    vecs[7]  = mk("unpaused",   1,   1'b0, 1, 11,  0, 0);
    vecs[8]  = mk("rise_top",   244, 1'b0, 2, 255, 0, 0);
    vecs[9]  = mk("day_again",  3,   1'b0, 3, 255, 1, 0);
    vecs[10] = mk("set_to_100", 155, 1'b0, 3, 100, 1, 0);

    rst_n   = 1'b0;
    vsync   = 1'b0;
    pause   = 1'b0;
    restart = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    check("reset_phase", phase, 0);
    check("reset_fade", fade_level, 0);
    check("reset_dir", direction, 1);
    check("reset_done", cycle_done, 0);

    // Table-driven rows: push the expectation when stimulus starts, pop after it completes.
    for (int i = 0; i < 11; i++) begin
      pause     = vecs[i].pz;
      done_seen = 0;
      sb.push_back(vecs[i]);
      pulses(vecs[i].n_pulses);
      exp_v = sb.pop_front();
      check({exp_v.name, "_phase"}, phase, exp_v.ph);
      check({exp_v.name, "_fade"}, fade_level, exp_v.fade);
      check({exp_v.name, "_dir"}, direction, exp_v.dir);
      check({exp_v.name, "_done_cnt"}, done_seen, exp_v.done);
    end
    pause = 1'b0;

    // restart coincident with a vsync rising edge in SET
    vsync   = 1'b1;
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    check("restart_phase", phase, 1);
    check("restart_fade", fade_level, 0);
    check("restart_dir", direction, 0);
    check("restart_done", cycle_done, 0);
    repeat (3) cyc();
    vsync = 1'b0;
    repeat (4) cyc();
    pulse();
    check("after_restart_fade", fade_level, 1);

    // Prescaler: dut3 steps on every third pulse after a clean restart
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    check("pre_restart_phase", phase3, 1);
    for (int k = 1; k <= 6; k++) begin
      q3.push_back(k / 3);
      pulse();
      check($sformatf("pre_fade_p%0d", k), fade3, q3.pop_front());
    end
    check("step1_fade_after_6", fade_level, 6);

    // Reset in DAY, then held vsync
    pulses(249);
    check("day_reached_phase", phase, 2);
    check("day_reached_fade", fade_level, 255);
    pulse();
    rst_n = 1'b0;
    cyc();
    check("midreset_phase", phase, 0);
    check("midreset_fade", fade_level, 0);
    check("midreset_dir", direction, 1);
    check("midreset_done", cycle_done, 0);
    rst_n = 1'b1;
    cyc();
    vsync = 1'b1;
    repeat (20) cyc();
    check("held_vsync_phase", phase, 0);
    vsync = 1'b0;
    repeat (4) cyc();
    done_seen = 0;
    pulse();
    check("held_then_wrap_phase", phase, 1);
    check("held_then_wrap_done", done_seen, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
